// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Central stall/flush controller for the 5-stage pipeline. Combines the forwarding unit's
//   data_shadow hazard, fetch/data cache handshakes, EX branch resolution and MEM halt into
//   per-latch enable/flush controls and the PC enable. Also keeps a sticky halt latch,
//   saturating stall/flush counters and a watchdog on back-to-back data_shadow stalls.
//
// Ports
//   CLK, nRST      clock, synchronous active-low reset
//   ihit, dhit     fetch / data access complete this cycle
//   mem_access     MEM-stage instruction reads or writes data memory
//   data_shadow    EX operand/order hazard against MEM (from the forwarding unit)
//   branch_taken   EX redirect
//   halt           HALT instruction valid in MEM
//   pc_en          PC update enable
//   *_en, *_flush  latch enable / bubble insert (flush wins over enable)
//   halted         registered, sticky halt status
//   stall_cnt      saturating count of non-halted cycles with pc_en=0
//   flush_cnt      saturating count of branch redirects taken
//   shadow_err     sticky data_shadow watchdog error
module pipeline_hazard_ctrl #(
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned SHADOW_LIMIT = 2
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_access,
    input  logic             data_shadow,
    input  logic             branch_taken,
    input  logic             halt,
    output logic             pc_en,
    output logic             fd_en,
    output logic             de_en,
    output logic             em_en,
    output logic             mw_en,
    output logic             fd_flush,
    output logic             de_flush,
    output logic             em_flush,
    output logic             mw_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             shadow_err
);

    // Run counter only needs to reach SHADOW_LIMIT; +2 keeps the width >= 1 for any limit.
    localparam int unsigned RunW = $clog2(SHADOW_LIMIT + 2);

    typedef enum logic [1:0] {
        StRun,
        StDwait,
        StHalted
    } state_e;

    state_e            state_q, state_d;
    logic              halted_q;
    logic [CNT_W-1:0]  stall_q;
    logic [CNT_W-1:0]  flush_q;
    logic              err_q;
    logic [RunW-1:0]   run_q;
    logic              shadow_sel;
    logic              branch_sel;

    // Mealy enables/flushes and next state.
    always_comb begin
        pc_en      = 1'b1;
        fd_en      = 1'b1;
        de_en      = 1'b1;
        em_en      = 1'b1;
        mw_en      = 1'b1;
        fd_flush   = 1'b0;
        de_flush   = 1'b0;
        em_flush   = 1'b0;
        mw_flush   = 1'b0;
        shadow_sel = 1'b0;
        branch_sel = 1'b0;
        state_d    = state_q;

        if (!nRST) begin
            pc_en    = 1'b0;
            fd_en    = 1'b0;
            de_en    = 1'b0;
            em_en    = 1'b0;
            mw_en    = 1'b0;
            fd_flush = 1'b1;
            de_flush = 1'b1;
            em_flush = 1'b1;
            mw_flush = 1'b1;
            state_d  = StRun;
        end else begin
            case (state_q)
                StHalted: begin
                    pc_en = 1'b0;
                    fd_en = 1'b0;
                    de_en = 1'b0;
                    em_en = 1'b0;
                    mw_en = 1'b0;
                end
                default: begin
                    // A pending data access (new or still outstanding) blocks everything
                    // except the halt check, which only runs once dhit arrives in DWAIT.
                    if (state_q == StDwait && !dhit) begin
                        pc_en    = 1'b0;
                        fd_en    = 1'b0;
                        de_en    = 1'b0;
                        em_en    = 1'b0;
                        mw_flush = 1'b1;
                        state_d  = StDwait;
                    end else if (halt) begin
                        pc_en   = 1'b0;
                        fd_en   = 1'b0;
                        de_en   = 1'b0;
                        em_en   = 1'b0;
                        mw_en   = 1'b0;
                        state_d = StHalted;
                    end else if (mem_access && !dhit) begin
                        pc_en    = 1'b0;
                        fd_en    = 1'b0;
                        de_en    = 1'b0;
                        em_en    = 1'b0;
                        mw_flush = 1'b1;
                        state_d  = StDwait;
                    end else begin
                        state_d = StRun;
                        if (data_shadow) begin
                            // Any concurrent branch is dropped; EX re-resolves it next cycle.
                            pc_en      = 1'b0;
                            fd_en      = 1'b0;
                            de_en      = 1'b0;
                            em_flush   = 1'b1;
                            shadow_sel = 1'b1;
                        end else if (branch_taken) begin
                            fd_flush   = 1'b1;
                            de_flush   = 1'b1;
                            branch_sel = 1'b1;
                        end else if (!ihit) begin
                            pc_en    = 1'b0;
                            fd_flush = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q  <= StRun;
            halted_q <= 1'b0;
            stall_q  <= '0;
            flush_q  <= '0;
            err_q    <= 1'b0;
            run_q    <= '0;
        end else begin
            state_q  <= state_d;
            halted_q <= (state_d == StHalted);
            if (state_q != StHalted) begin
                if (!pc_en && stall_q != '1) begin
                    stall_q <= stall_q + CNT_W'(1);
                end
                if (branch_sel && flush_q != '1) begin
                    flush_q <= flush_q + CNT_W'(1);
                end
            end
            // run_q parks at SHADOW_LIMIT; one more shadow cycle trips the error.
            if (shadow_sel) begin
                if (run_q >= RunW'(SHADOW_LIMIT)) begin
                    err_q <= 1'b1;
                end else begin
                    run_q <= run_q + RunW'(1);
                end
            end else begin
                run_q <= '0;
            end
        end
    end

    assign halted     = halted_q;
    assign stall_cnt  = stall_q;
    assign flush_cnt  = flush_q;
    assign shadow_err = err_q;

endmodule
